uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART 8N1 receiver: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.
- Pairs with the existing transmitter on the serial link.
- Samples the asynchronous rx line in the clk domain at each bit midpoint.
- Delivers each byte with a one-cycle valid strobe and flags framing errors.

Parameters:
- BAUD_DIV, 434, clk cycles per bit (50 MHz / 115200). Legal range ≥ 4.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset: synchronous, active-high.
- rx  input  1  serial input, asynchronous to clk; idle high.
- data_out  output  8  last correctly framed byte; held until the next good byte.
- rx_valid  output  1  one-cycle strobe: data_out has just been updated.
- frame_err  output  1  one-cycle strobe: stop bit sampled low.
- rx_busy  output  1  high while a frame is being received.

Behaviour:
- Reset (rst=1 at a clk edge):
  - data_out=0x00, rx_valid=0, frame_err=0, rx_busy=0.
  - Both synchronizer flops = 1; state=IDLE; bit counter and baud counter = 0.
  - Reset mid-frame abandons the frame with no strobe.
- Synchronizer: rx passes through 2 flops to give rx_s. All decisions use rx_s only.
- Baud counter:
  - Runs 0..BAUD_DIV-1, cleared on every state entry.
  - Half-bit point is BAUD_DIV/2 - 1 (integer division).
- States:
  - IDLE: rx_busy=0. When rx_s=0, go to START.
  - START: rx_busy=1. At half-bit, if rx_s=0 go to DATA with bit index 0. If rx_s=1 it was a glitch: return to IDLE with no strobe.
  - DATA: at count BAUD_DIV-1, shift rx_s into the shift register at the current index (LSB first). After index 7 is sampled, go to STOP.
  - STOP: at count BAUD_DIV-1, sample the stop bit.
    - rx_s=1: data_out <= shift register; rx_valid=1 for exactly 1 cycle; go to IDLE.
    - rx_s=0: frame_err=1 for exactly 1 cycle; data_out unchanged; rx_valid stays 0; go to WAIT_HIGH.
  - WAIT_HIGH: rx_busy=1. Stay until rx_s=1, then go to IDLE. This prevents a break (line held low) from being decoded as a string of 0x00 frames.
- Timing:
  - Every sample lands at a bit midpoint (±1 clk).
  - Return to IDLE happens mid-stop-bit, so back-to-back frames with a single stop bit are received without loss.
- Latency: rx_valid rises 2 + BAUD_DIV/2 + 9·BAUD_DIV (±2) clk cycles after the start-bit falling edge on rx.
- rx_valid and frame_err are mutually exclusive. Neither is asserted while rst=1.
- rx_busy drops in the same cycle that rx_valid or frame_err is asserted, except when going to WAIT_HIGH, where it stays high.
- There is no input handshake and no buffering. A consumer that misses the strobe may still read data_out until the next good byte.

Test Plan:
- Frame 0x55, BAUD_DIV=434, driven bit-by-bit (20 ns clk) -> exactly one rx_valid pulse; data_out=0x55; rx_valid at 2+217+3906 ±2 cycles after the start edge; frame_err never asserted.
- Frames 0xA3 then 0x00 back-to-back, one stop bit each, no idle gap -> two rx_valid pulses with data_out 0xA3 then 0x00.
- rx low glitch of 100 cycles (< BAUD_DIV/2) -> no strobes; rx_busy returns to 0 about 217 cycles later; a following 0x3C frame is received correctly.
- Frame 0xF0 with stop bit low, line held low for 3 bit times, then released, then frame 0x81 -> frame_err pulses once; data_out keeps its previous value; no extra frames or strobes during the low period; then 0x81 received with rx_valid.
- rst asserted for 1 cycle in the middle of data bit 4 of frame 0x5A -> all outputs return to reset values; no strobe; a following frame 0xC3 is received correctly.
- Loopback: the team's transmitter (BAUD_DIV=434) sends 0x55, 0xA3, 0xFF, 0x00 into rx -> four rx_valid pulses with matching data_out and zero frame_err.

Source files
------------

// File: rtl/uart_rx.sv
// UART 8N1 receiver: two-flop synchronizer, mid-bit sampling, one-cycle
// valid/frame-error strobes, and a wait-for-high guard after a bad stop bit.
module uart_rx #(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          rx_m;
    logic          rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          take_bit;
    logic          good_stop;
    logic          bad_stop;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        take_bit   = 1'b0;
        good_stop  = 1'b0;
        bad_stop   = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) state_next = START;
            end
            START: begin
                // Start bit re-checked at its midpoint to reject short glitches.
                if (cnt == HALF) state_next = rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (cnt == LAST) begin
                    take_bit = 1'b1;
                    if (bit_idx == 3'd7) state_next = STOP;
                end
            end
            STOP: begin
                if (cnt == LAST) begin
                    if (rx_s) begin
                        good_stop  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        bad_stop   = 1'b1;
                        state_next = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                if (rx_s) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            data_out  <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            // Counter restarts on every state change so sample points track entry.
            if (state_next != state || cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (state == START && state_next == DATA) begin
                bit_idx <= '0;
            end else if (take_bit) begin
                shreg[bit_idx] <= rx_s;
                bit_idx        <= bit_idx + 1'b1;
            end
            if (good_stop) begin
                data_out <= shreg;
            end
            rx_valid  <= good_stop;
            frame_err <= bad_stop;
        end
    end

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: bit-level frames, glitch, framing error,
// mid-frame reset and a clocked transmitter loopback.
module tb_uart_rx;

    localparam int BAUD = 434;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_drv = 1'b1;
    logic       use_tx = 1'b0;
    logic       rx;
    logic [7:0] data_out;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         n_valid = 0;
    int         n_ferr = 0;
    int         n_busy_bad = 0;
    int         n_excl = 0;
    int         last_valid_cyc = 0;
    logic [7:0] vq[$];

    logic       tx_load = 1'b0;
    logic [7:0] tx_byte = '0;
    logic [9:0] tx_sh = '1;
    logic [3:0] tx_bits = '0;
    int         tx_cnt = 0;
    logic       tx_line;

    uart_rx #(.BAUD_DIV(BAUD)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .data_out (data_out),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .rx_busy  (rx_busy)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Simple clocked transmitter standing in for the link partner.
    always @(posedge clk) begin
        if (tx_load && tx_bits == 0) begin
            tx_sh   <= {1'b1, tx_byte, 1'b0};
            tx_bits <= 4'd10;
            tx_cnt  <= 0;
        end else if (tx_bits != 0) begin
            if (tx_cnt == BAUD - 1) begin
                tx_cnt  <= 0;
                tx_sh   <= {1'b1, tx_sh[9:1]};
                tx_bits <= tx_bits - 1'b1;
            end else begin
                tx_cnt <= tx_cnt + 1;
            end
        end
    end
    assign tx_line = (tx_bits != 0) ? tx_sh[0] : 1'b1;
    assign rx      = use_tx ? tx_line : rx_drv;

    always @(negedge clk) begin
        if (rx_valid) begin
            n_valid++;
            vq.push_back(data_out);
            last_valid_cyc = cyc;
            if (rx_busy) n_busy_bad++;
            if (frame_err) n_excl++;
        end
        if (frame_err) n_ferr++;
        if (rst && (rx_valid || frame_err)) n_excl++;
    end

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog cycle budget exceeded");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_drv = bits[i];
            wait_cycles(BAUD);
        end
    endtask

    task automatic expect_bytes(input string tag, input int n, input logic [31:0] b0, input logic [31:0] b1);
        check({tag, "_count"}, vq.size(), n);
        if (n > 0 && vq.size() > 0) check({tag, "_b0"}, vq.pop_front(), b0);
        if (n > 1 && vq.size() > 0) check({tag, "_b1"}, vq.pop_front(), b1);
        vq.delete();
    endtask

    initial begin
        int start_cyc;
        int lat;
        int f0;
        int v0;

        wait_cycles(5);
        check("rst_data", data_out, 8'h00);
        check("rst_valid", rx_valid, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_busy", rx_busy, 1'b0);
        rst = 1'b0;
        wait_cycles(20);

        start_cyc = cyc;
        send_frame(8'h55, 1'b1);
        wait_cycles(10);
        expect_bytes("f55", 1, 8'h55, 0);
        lat = last_valid_cyc - start_cyc;
        if (lat < 4123 || lat > 4127) $display("latency measured %0d cycles", lat);
        check("latency_in_window", 32'(lat >= 4123 && lat <= 4127), 1);
        check("f55_no_ferr", n_ferr, 0);
        check("f55_data_held", data_out, 8'h55);

        send_frame(8'hA3, 1'b1);
        send_frame(8'h00, 1'b1);
        wait_cycles(10);
        expect_bytes("b2b", 2, 8'hA3, 8'h00);

        v0 = n_valid;
        rx_drv = 1'b0;
        wait_cycles(100);
        rx_drv = 1'b1;
        wait_cycles(50);
        check("glitch_busy_hi", rx_busy, 1'b1);
        wait_cycles(80);
        check("glitch_busy_lo", rx_busy, 1'b0);
        check("glitch_no_valid", n_valid - v0, 0);
        check("glitch_no_ferr", n_ferr, 0);
        send_frame(8'h3C, 1'b1);
        wait_cycles(10);
        expect_bytes("f3c", 1, 8'h3C, 0);

        v0 = n_valid;
        f0 = n_ferr;
        send_frame(8'hF0, 1'b0);
        wait_cycles(3 * BAUD);
        check("break_busy", rx_busy, 1'b1);
        rx_drv = 1'b1;
        wait_cycles(BAUD);
        check("ferr_once", n_ferr - f0, 1);
        check("ferr_no_valid", n_valid - v0, 0);
        check("ferr_data_kept", data_out, 8'h3C);
        check("ferr_idle", rx_busy, 1'b0);
        send_frame(8'h81, 1'b1);
        wait_cycles(10);
        expect_bytes("f81", 1, 8'h81, 0);

        v0 = n_valid;
        f0 = n_ferr;
        begin
            logic [7:0] b;
            b = 8'h5A;
            rx_drv = 1'b0;
            wait_cycles(BAUD);
            for (int i = 0; i < 4; i++) begin
                rx_drv = b[i];
                wait_cycles(BAUD);
            end
            rx_drv = b[4];
            wait_cycles(BAUD / 2);
        end
        check("pre_rst_busy", rx_busy, 1'b1);
        rst = 1'b1;
        rx_drv = 1'b1;
        wait_cycles(1);
        rst = 1'b0;
        check("mid_rst_data", data_out, 8'h00);
        check("mid_rst_busy", rx_busy, 1'b0);
        check("mid_rst_valid", rx_valid, 1'b0);
        wait_cycles(BAUD);
        check("mid_rst_no_strobe", (n_valid - v0) + (n_ferr - f0), 0);
        send_frame(8'hC3, 1'b1);
        wait_cycles(10);
        expect_bytes("fc3", 1, 8'hC3, 0);

        f0 = n_ferr;
        use_tx = 1'b1;
        begin
            logic [7:0] lb[4];
            lb = '{8'h55, 8'hA3, 8'hFF, 8'h00};
            for (int k = 0; k < 4; k++) begin
                tx_byte = lb[k];
                tx_load = 1'b1;
                wait_cycles(1);
                tx_load = 1'b0;
                for (int n = 0; n < 11 * BAUD && tx_bits != 0; n++) wait_cycles(1);
                check("tx_done", tx_bits, 0);
            end
            wait_cycles(10);
            check("loop_count", vq.size(), 4);
            for (int k = 0; k < 4; k++) begin
                if (vq.size() > 0) check("loop_byte", vq.pop_front(), lb[k]);
            end
        end
        check("loop_no_ferr", n_ferr - f0, 0);
        check("busy_at_valid", n_busy_bad, 0);
        check("strobe_exclusive", n_excl, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
